// File: rtl/card_flip_ctrl_if.sv
// Card drawer handshake: the controller issues one card per draw pulse
// and waits for the drawer's done pulse before moving to the next slot.
interface card_flip_ctrl_if;
    logic       draw;
    logic       done;
    logic [2:0] card_num;
    logic       show;
    logic [2:0] slot;

    modport master (output draw, card_num, show, slot, input done);
    modport slave  (input draw, card_num, show, slot, output done);
endinterface

// File: rtl/card_flip_ctrl.sv
// Card-flip game controller: tracks picks and matches, resolves pairs after a
// visible hold, and sweeps the whole board through the card drawer on every change.
module card_flip_ctrl #(
    parameter int          NSLOT       = 8,
    parameter logic [23:0] LAYOUT      = 24'o32103210,
    parameter int          HOLD_CYCLES = 25_000_000,
    parameter int          HW          = 25
) (
    input  logic                Clock,
    input  logic                Resetn,
    input  logic [2:0]          sel,
    input  logic                flip,
    card_flip_ctrl_if.master    drw,
    output logic [NSLOT-1:0]    matched,
    output logic [2:0]          pairs,
    output logic                busy,
    output logic                win
);

    typedef enum logic [2:0] {G_PICK1, G_PICK2, G_HOLD, G_RESOLVE, G_WIN} game_state_t;
    typedef enum logic [1:0] {D_IDLE, D_ISSUE, D_WAIT} draw_state_t;

    game_state_t      game_reg;
    draw_state_t      dstate_reg, dstate_next;
    logic [NSLOT-1:0] face_up_reg;
    logic [NSLOT-1:0] matched_reg;
    logic [2:0]       first_reg;
    logic [2:0]       pairs_reg;
    logic             pend_reg, pend_next;
    logic [HW-1:0]    hold_cnt_reg;
    logic [2:0]       slot_reg, slot_next;
    logic             draw_reg, show_reg, busy_reg, win_reg;
    logic [2:0]       card_num_reg;

    logic [2:0]       face_val [NSLOT];
    logic [2:0]       second_slot;
    logic             busy_int, accept, load_slot;

    genvar gi;
    generate
        for (gi = 0; gi < NSLOT; gi++) begin : g_face
            assign face_val[gi] = LAYOUT[3*gi +: 3];
        end
    endgenerate

    // The partner of first_reg is the other set bit of face_up_reg.
    always_comb begin
        second_slot = 3'd0;
        for (int i = 0; i < NSLOT; i++) begin
            if (face_up_reg[i] && (3'(i) != first_reg))
                second_slot = 3'(i);
        end
    end

    assign busy_int = (dstate_reg != D_IDLE) || pend_reg;
    assign accept   = flip && !busy_int
                   && ((game_reg == G_PICK1) || (game_reg == G_PICK2))
                   && !matched_reg[sel] && !face_up_reg[sel];

    always_comb begin
        dstate_next = dstate_reg;
        slot_next   = slot_reg;
        load_slot   = 1'b0;
        case (dstate_reg)
            D_IDLE: begin
                if (pend_reg) begin
                    dstate_next = D_ISSUE;
                    slot_next   = 3'd0;
                    load_slot   = 1'b1;
                end
            end
            D_ISSUE: dstate_next = D_WAIT;
            D_WAIT: begin
                if (drw.done) begin
                    if (slot_reg == 3'd7) begin
                        dstate_next = D_IDLE;
                    end else begin
                        dstate_next = D_ISSUE;
                        slot_next   = slot_reg + 3'd1;
                        load_slot   = 1'b1;
                    end
                end
            end
            default: dstate_next = D_IDLE;
        endcase
    end

    // A request raised mid-sweep survives until the sweep returns to idle.
    always_comb begin
        pend_next = pend_reg;
        if (dstate_reg == D_IDLE && pend_reg)
            pend_next = 1'b0;
        if (accept || game_reg == G_RESOLVE)
            pend_next = 1'b1;
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            game_reg     <= G_PICK1;
            dstate_reg   <= D_IDLE;
            face_up_reg  <= '0;
            matched_reg  <= '0;
            first_reg    <= 3'd0;
            pairs_reg    <= 3'd0;
            pend_reg     <= 1'b1;
            hold_cnt_reg <= '0;
            slot_reg     <= 3'd0;
            draw_reg     <= 1'b0;
            show_reg     <= 1'b0;
            card_num_reg <= 3'd0;
            busy_reg     <= 1'b0;
            win_reg      <= 1'b0;
        end else begin
            dstate_reg <= dstate_next;
            slot_reg   <= slot_next;
            pend_reg   <= pend_next;
            draw_reg   <= (dstate_next == D_ISSUE);
            busy_reg   <= (dstate_next != D_IDLE) || pend_next;
            if (load_slot) begin
                card_num_reg <= face_val[slot_next];
                show_reg     <= face_up_reg[slot_next] | matched_reg[slot_next];
            end

            case (game_reg)
                G_PICK1: begin
                    if (accept) begin
                        face_up_reg[sel] <= 1'b1;
                        first_reg        <= sel;
                        game_reg         <= G_PICK2;
                    end
                end
                G_PICK2: begin
                    if (accept) begin
                        face_up_reg[sel] <= 1'b1;
                        hold_cnt_reg     <= '0;
                        game_reg         <= G_HOLD;
                    end
                end
                G_HOLD: begin
                    // The hold only starts counting once the reveal sweep is on screen.
                    if (!busy_int) begin
                        if (hold_cnt_reg == HW'(HOLD_CYCLES - 1))
                            game_reg <= G_RESOLVE;
                        else
                            hold_cnt_reg <= hold_cnt_reg + 1'b1;
                    end
                end
                G_RESOLVE: begin
                    face_up_reg <= '0;
                    game_reg    <= G_PICK1;
                    if (face_val[first_reg] == face_val[second_slot]) begin
                        matched_reg[first_reg]   <= 1'b1;
                        matched_reg[second_slot] <= 1'b1;
                        pairs_reg                <= pairs_reg + 3'd1;
                        if (pairs_reg == 3'd3) begin
                            game_reg <= G_WIN;
                            win_reg  <= 1'b1;
                        end
                    end
                end
                G_WIN: game_reg <= G_WIN;
                default: game_reg <= G_PICK1;
            endcase
        end
    end

    assign drw.draw     = draw_reg;
    assign drw.card_num = card_num_reg;
    assign drw.show     = show_reg;
    assign drw.slot     = slot_reg;
    assign matched      = matched_reg;
    assign pairs        = pairs_reg;
    assign busy         = busy_reg;
    assign win          = win_reg;

endmodule

// File: tb/tb_card_flip_ctrl.sv
// Bench for card_flip_ctrl: a drawer model answers each draw 5 cycles later and
// checks every drawn card against a queue of expected cards built from a board model.
module tb_card_flip_ctrl;

    logic       Clock = 1'b0;
    logic       Resetn = 1'b0;
    logic [2:0] sel = 3'd0;
    logic       flip = 1'b0;
    logic [7:0] matched;
    logic [2:0] pairs;
    logic       busy, win;

    card_flip_ctrl_if drw();

    card_flip_ctrl #(.HOLD_CYCLES(4)) dut (
        .Clock   (Clock),
        .Resetn  (Resetn),
        .sel     (sel),
        .flip    (flip),
        .drw     (drw),
        .matched (matched),
        .pairs   (pairs),
        .busy    (busy),
        .win     (win)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic [2:0] slot;
        logic       show;
        logic [2:0] card;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] m_face;
    logic [7:0] m_matched;
    logic       seen5 = 1'b0;
    int         n_checks = 0;
    int         n_fail = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] face_of(input int s);
        return 3'(s % 4);
    endfunction

    task automatic push_sweep();
        exp_t e;
        for (int s = 0; s < 8; s++) begin
            e.slot = 3'(s);
            e.show = m_face[s] | m_matched[s];
            e.card = face_of(s);
            sb.push_back(e);
        end
    endtask

    // Drawer model: checks each card on draw, answers with done 5 cycles later.
    initial begin
        int   cnt;
        exp_t e;
        cnt = 0;
        drw.done = 1'b0;
        forever begin
            @(negedge Clock);
            drw.done = 1'b0;
            if (!Resetn) begin
                cnt = 0;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) drw.done = 1'b1;
            end
            if (Resetn && drw.draw) begin
                $display("draw slot=%0d show=%0d card=%0d", drw.slot, drw.show, drw.card_num);
                if (sb.size() == 0) begin
                    check_val("draw_expected", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    check_val("slot", 32'(drw.slot), 32'(e.slot));
                    check_val("show", 32'(drw.show), 32'(e.show));
                    check_val("card_num", 32'(drw.card_num), 32'(e.card));
                end
                if (drw.slot == 3'd5) seen5 = 1'b1;
                cnt = 5;
            end
        end
    end

    task automatic wait_quiet();
        for (int i = 0; i < 600; i++) begin
            @(negedge Clock);
            if (sb.size() == 0 && !busy) break;
        end
        check_val("quiet_queue", 32'(sb.size()), 32'd0);
        check_val("quiet_busy", 32'(busy), 32'd0);
    endtask

    task automatic drive_flip(input int s);
        @(negedge Clock);
        sel  = 3'(s);
        flip = 1'b1;
        @(negedge Clock);
        flip = 1'b0;
        $display("flip sel=%0d", s);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_draw"}, 32'(drw.draw), 32'd0);
        check_val({tag, "_slot"}, 32'(drw.slot), 32'd0);
        check_val({tag, "_card"}, 32'(drw.card_num), 32'd0);
        check_val({tag, "_show"}, 32'(drw.show), 32'd0);
        check_val({tag, "_matched"}, 32'(matched), 32'd0);
        check_val({tag, "_pairs"}, 32'(pairs), 32'd0);
        check_val({tag, "_busy"}, 32'(busy), 32'd0);
        check_val({tag, "_win"}, 32'(win), 32'd0);
    endtask

    // probe: 0 none, 1 drop a flip during the hold, 2 drop a flip during the reveal sweep
    task automatic pick_pair(input int a, input int b, input int probe, input int probe_slot);
        m_face[a] = 1'b1;
        push_sweep();
        drive_flip(a);
        wait_quiet();
        drive_flip(a);
        repeat (2) @(negedge Clock);
        check_val("face_up_drop_busy", 32'(busy), 32'd0);
        m_face[b] = 1'b1;
        push_sweep();
        if (face_of(a) == face_of(b)) begin
            m_matched[a] = 1'b1;
            m_matched[b] = 1'b1;
        end
        m_face = '0;
        push_sweep();
        drive_flip(b);
        if (probe == 2) begin
            check_val("sweep_busy", 32'(busy), 32'd1);
            drive_flip(probe_slot);
        end else if (probe == 1) begin
            for (int i = 0; i < 200; i++) begin
                @(negedge Clock);
                if (sb.size() == 8 && !busy) break;
            end
            check_val("hold_queue", 32'(sb.size()), 32'd8);
            sel  = 3'(probe_slot);
            flip = 1'b1;
            @(negedge Clock);
            flip = 1'b0;
            $display("flip sel=%0d (in hold)", probe_slot);
        end
        wait_quiet();
    endtask

    initial begin
        m_face    = '0;
        m_matched = '0;
        Resetn    = 1'b0;
        repeat (3) @(negedge Clock);
        check_reset_outputs("reset");

        push_sweep();
        Resetn = 1'b1;
        wait_quiet();
        check_val("init_matched", 32'(matched), 32'd0);
        check_val("init_pairs", 32'(pairs), 32'd0);

        pick_pair(0, 4, 1, 1);
        check_val("p1_matched", 32'(matched), 32'h11);
        check_val("p1_pairs", 32'(pairs), 32'd1);

        drive_flip(0);
        repeat (2) @(negedge Clock);
        check_val("matched_drop_busy", 32'(busy), 32'd0);

        pick_pair(1, 2, 2, 3);
        check_val("miss_matched", 32'(matched), 32'h11);
        check_val("miss_pairs", 32'(pairs), 32'd1);
        check_val("miss_win", 32'(win), 32'd0);

        pick_pair(1, 5, 0, 0);
        pick_pair(2, 6, 0, 0);
        check_val("p3_pairs", 32'(pairs), 32'd3);
        check_val("p3_win", 32'(win), 32'd0);
        pick_pair(3, 7, 0, 0);
        check_val("win_pairs", 32'(pairs), 32'd4);
        check_val("win_matched", 32'(matched), 32'hff);
        check_val("win_flag", 32'(win), 32'd1);

        drive_flip(0);
        drive_flip(6);
        repeat (20) @(negedge Clock);
        check_val("win_hold", 32'(win), 32'd1);
        check_val("win_busy", 32'(busy), 32'd0);

        // Reset after the win, then again in the middle of the reset sweep.
        Resetn = 1'b0;
        sb.delete();
        m_face = '0;
        m_matched = '0;
        @(negedge Clock);
        check_reset_outputs("rst_win");
        push_sweep();
        seen5 = 1'b0;
        Resetn = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge Clock);
            if (seen5) break;
        end
        check_val("seen_slot5", 32'(seen5), 32'd1);
        check_val("mid_sweep_queue", 32'(sb.size()), 32'd2);
        Resetn = 1'b0;
        sb.delete();
        @(negedge Clock);
        check_reset_outputs("rst_sweep");
        push_sweep();
        Resetn = 1'b1;
        wait_quiet();

        // Reset in the middle of a hold.
        m_face[0] = 1'b1;
        push_sweep();
        drive_flip(0);
        wait_quiet();
        m_face[4] = 1'b1;
        push_sweep();
        drive_flip(4);
        for (int i = 0; i < 200; i++) begin
            @(negedge Clock);
            if (sb.size() == 0 && !busy) break;
        end
        check_val("hold_reached", 32'(sb.size()), 32'd0);
        Resetn = 1'b0;
        m_face = '0;
        @(negedge Clock);
        check_reset_outputs("rst_hold");
        push_sweep();
        Resetn = 1'b1;
        wait_quiet();
        repeat (10) @(negedge Clock);
        check_val("post_hold_reset_matched", 32'(matched), 32'd0);
        check_val("post_hold_reset_pairs", 32'(pairs), 32'd0);
        check_val("final_queue", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
